// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_pkg
//  Description : Shared state encoding, error codes and helpers for the UART
//                frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    // Frame controller state encoding (3-bit)
    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    typedef enum logic [2:0] {
        HUNT    = ST_HUNT,
        LEN     = ST_LEN,
        PAYLOAD = ST_PAYLOAD,
        CHECK   = ST_CHECK,
        DRAIN   = ST_DRAIN
    } frm_state_t;

    // Error codes reported on o_Err_Code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Default frame start marker
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // A length byte is acceptable when it is non-zero and fits the buffer
    function automatic logic len_ok(input logic [7:0] b, input int unsigned max_len);
        return (b != 8'd0) && ({24'd0, b} <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_buf
//  Description : DEPTH x 8 simple dual-port RAM, one write port, one read
//                port with a 1-clock registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    // Write port and registered read port; no reset on storage
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_ctrl
//  Description : Hunts for SYNC_BYTE, parses a length-prefixed checksummed
//                frame into a local buffer and releases good frames as a
//                valid/ready byte stream with a last-byte marker.
//                Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         MAX_LEN      = 64,
    parameter int         TIMEOUT_CLKS = 100000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Frm_Valid,
    input  logic       i_Frm_Ready,
    output logic [7:0] o_Frm_Byte,
    output logic       o_Frm_Last,
    output logic       o_Frm_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Rx_Drop,
    output logic       o_Busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    frm_state_t    state_q;
    logic [IW-1:0] len_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    acc_q;
    logic [IW-1:0] nxt_q;
    logic [IW-1:0] nxt_d;
    logic          valid_q;
    logic [7:0]    byte_q;
    logic          last_q;
    logic          err_q;
    logic [1:0]    code_q;
    logic          drop_q;

    logic          w_in_frame;
    logic          w_load;
    logic          w_tmo_exp;
    logic          w_wr_en;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;

    assign w_in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);

    // Output register can take a new byte when empty or being consumed
    assign w_load = (state_q == DRAIN) && (nxt_q < len_q) && (!valid_q || i_Frm_Ready);

    // nxt_q is the buffer index the output register loads next; the RAM is
    // addressed with its next value so its registered data is always ready
    always_comb begin
        nxt_d = nxt_q;
        if (state_q != DRAIN) begin
            nxt_d = '0;
        end else if (w_load) begin
            nxt_d = nxt_q + 1'b1;
        end
    end

    assign w_rd_addr = (nxt_d < IW'(MAX_LEN)) ? nxt_d[AW-1:0] : '0;
    assign w_wr_en   = (state_q == PAYLOAD) && i_Rx_DV;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i     (i_Clock),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (idx_q[AW-1:0]),
        .wr_data_i (i_Rx_Byte),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_rd_data)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [TW-1:0] tmo_q;

    // Expiry only counts when no strobe arrives on the same cycle
    assign w_tmo_exp = w_in_frame && !i_Rx_DV && (tmo_q == TW'(TIMEOUT_CLKS - 1));

    // Inter-byte idle counter, cleared by every strobe and outside a frame
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            tmo_q <= '0;
        end else if (i_Rx_DV || !w_in_frame) begin
            tmo_q <= '0;
        end else if (!w_tmo_exp) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign w_tmo_exp = 1'b0;
`endif

    // Frame FSM with registered stream, error and drop outputs
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q <= HUNT;
            len_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            nxt_q   <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            drop_q  <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            drop_q <= 1'b0;
            nxt_q  <= nxt_d;
            unique case (state_q)
                HUNT: begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    if (i_Rx_DV) begin
                        if (!len_ok(i_Rx_Byte, MAX_LEN)) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_LEN;
                            state_q <= HUNT;
                        end else begin
                            len_q   <= IW'(i_Rx_Byte);
                            acc_q   <= i_Rx_Byte;
                            idx_q   <= '0;
                            state_q <= PAYLOAD;
                        end
                    end else if (w_tmo_exp) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_TIMEOUT;
                        state_q <= HUNT;
                    end
                end
                PAYLOAD: begin
                    // A SYNC_BYTE here is ordinary data
                    if (i_Rx_DV) begin
                        acc_q <= acc_q + i_Rx_Byte;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == len_q - 1'b1) begin
                            state_q <= CHECK;
                        end
                    end else if (w_tmo_exp) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_TIMEOUT;
                        state_q <= HUNT;
                    end
                end
                CHECK: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == acc_q) begin
                            state_q <= DRAIN;
                        end else begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_CHK;
                            state_q <= HUNT;
                        end
                    end else if (w_tmo_exp) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_TIMEOUT;
                        state_q <= HUNT;
                    end
                end
                DRAIN: begin
                    // The receiver cannot be stalled, so bytes here are lost
                    drop_q <= i_Rx_DV;
                    if (w_load) begin
                        valid_q <= 1'b1;
                        byte_q  <= w_rd_data;
                        last_q  <= (nxt_q == len_q - 1'b1);
                    end else if (i_Frm_Ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                    if (valid_q && i_Frm_Ready && last_q) begin
                        state_q <= HUNT;
                    end
                end
                default: begin
                    state_q <= HUNT;
                end
            endcase
        end
    end

    assign o_Frm_Valid = valid_q;
    assign o_Frm_Byte  = byte_q;
    assign o_Frm_Last  = last_q;
    assign o_Frm_Err   = err_q;
    assign o_Err_Code  = code_q;
    assign o_Rx_Drop   = drop_q;
    assign o_Busy      = (state_q != HUNT);

endmodule
`default_nettype wire
